instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/riscv_fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/instr_fetch.sv | 100 ++++++++++
 3 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared widths, defaults and the FIFO entry type for the instruction fetch unit.
package riscv_fetch_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam int unsigned     ROM_WORDS_DEFAULT = 40;

   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   // Word index presented to the instruction memory for a byte address.
   function automatic logic [XLEN-1:0] word_index(input logic [XLEN-1:0] byte_addr);
      return byte_addr >> 2;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {instr, pc} queue between the memory response and the decode side.
// Slot 0 is always the head, so the head outputs come straight from a register.
module fetch_fifo
   import riscv_fetch_pkg::*;
(
   input  logic         clock,
   input  logic         reset_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   output fetch_entry_t head,
   output logic         full,
   output logic         empty,
   output logic [1:0]   occupancy
);

   fetch_entry_t ent0_q, ent0_d;
   fetch_entry_t ent1_q, ent1_d;
   logic [1:0]   count_q, count_d;

   // Shift on pop, land a push in the first free slot after any pop; flush only drops the count.
   always_comb begin
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      count_d = count_q;
      if (flush) begin
         count_d = 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_q == 2'd0) begin
                  ent0_d = push_entry;
               end else begin
                  ent1_d = push_entry;
               end
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               ent0_d  = ent1_q;
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  ent0_d = push_entry;
               end else begin
                  ent0_d = ent1_q;
                  ent1_d = push_entry;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Storage and occupancy registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ent0_q  <= '0;
         ent1_q  <= '0;
         count_q <= 2'd0;
      end else begin
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
         count_q <= count_d;
      end
   end

   assign head      = ent0_q;
   assign occupancy = count_q;
   assign full      = (count_q == 2'd2);
   assign empty     = (count_q == 2'd0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: byte PC, issue control, one outstanding memory read and
// redirect handling, feeding a two-entry queue toward decode.
module instr_fetch
   import riscv_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int unsigned     ROM_WORDS = ROM_WORDS_DEFAULT
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] mem_add,
   output logic            mem_enable,
   input  logic [ILEN-1:0] mem_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [ILEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc
);

   // One bit wider than the PC so the end-of-ROM address never wraps.
   localparam logic [XLEN:0]   PC_LIMIT   = (XLEN+1)'(ROM_WORDS) << 2;
   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
   logic            inflight_q, inflight_d;

   logic            deq;
   logic            issue;
   logic            push;
   logic            in_range;
   logic [2:0]      slots;

   fetch_entry_t    head;
   fetch_entry_t    push_entry;
   logic            fifo_full;
   logic            fifo_empty;
   logic [1:0]      fifo_occ;

   // Issue and enqueue decisions. Issue reserves a queue slot for its response, counting
   // this cycle's dequeue so a drained slot can be refilled back to back.
   always_comb begin
      deq              = !fifo_empty && out_ready;
      in_range         = ({1'b0, pc_q} < PC_LIMIT);
      slots            = {1'b0, fifo_occ} + {2'b00, inflight_q} - {2'b00, deq};
      issue            = reset_n && !redirect_valid && in_range && (slots < 3'd2);
      push             = reset_n && inflight_q && !redirect_valid && (!fifo_full || deq);
      push_entry.instr = mem_instr;
      push_entry.pc    = inflight_pc_q;
   end

   // Next PC and in-flight tracking; a redirect overrides the sequential advance.
   always_comb begin
      pc_d          = pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      if (redirect_valid) begin
         pc_d = redirect_pc & ALIGN_MASK;
      end else if (issue) begin
         pc_d          = pc_q + XLEN'(4);
         inflight_pc_d = pc_q;
      end
   end

   // PC and outstanding-read registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   fetch_fifo u_fifo (
      .clock      (clock),
      .reset_n    (reset_n),
      .flush      (redirect_valid),
      .push       (push),
      .push_entry (push_entry),
      .pop        (deq),
      .head       (head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .occupancy  (fifo_occ)
   );

   // mem_enable must follow same-cycle redirect and ready, so it is the issue decision itself.
   assign mem_add    = word_index(pc_q);
   assign mem_enable = issue;
   assign out_valid  = !fifo_empty;
   assign out_instr  = head.instr;
   assign out_pc     = head.pc;

endmodule
